mem_access_unit: RTL and testbench

Data-memory access unit for the memory stage of the MIPS-32 pipeline. It is the consumer of the decoder's `memen`/`memwrite` control. It turns one load/store per instruction into a transaction on the SRAM-like data bus (`req`/`addr_ok`/`data_ok`), and stalls the pipeline until the transaction finishes. It also aligns and extends load data, replicates store data across byte lanes, and flags misaligned addresses as address-error exceptions.

---
 rtl/mem_access_unit.sv | 140 ++++++++++++++
 tb/tb_mem_access_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: drives one SRAM-like bus transaction per
// instruction, stalls the pipeline until it completes, and aligns load data.
module mem_access_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  input  logic        memen,
  input  logic        memwrite,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata_in,
  input  logic        advance,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        adel,
  output logic        ades,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;

  state_t      state, state_nxt;
  logic        drain_addr_done, drain_addr_done_nxt;
  logic        ld_sign;
  logic        mis, start;
  logic [1:0]  size_map;
  logic [31:0] wdata_rep;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_aligned;

  always_comb begin
    case (size)
      2'd0:    mis = 1'b0;
      2'd1:    mis = addr[0];
      default: mis = |addr[1:0];
    endcase
  end

  assign size_map = (size == 2'd3) ? 2'd2 : size;
  assign adel  = valid & memen & ~memwrite & mis;
  assign ades  = valid & memen &  memwrite & mis;
  assign start = valid & memen & ~mis & ~flush & (state == S_IDLE);
  // A drain still owns the bus, so any new memory op must wait behind it.
  assign stall = (valid & memen & ~mis & ~flush & (state != S_DONE)) |
                 (valid & memen & (state == S_DRAIN));

  always_comb begin
    case (size_map)
      2'd0:    wdata_rep = {4{wdata_in[7:0]}};
      2'd1:    wdata_rep = {2{wdata_in[15:0]}};
      default: wdata_rep = wdata_in;
    endcase
  end

  always_comb begin
    case (data_addr[1:0])
      2'd0:    ld_byte = data_rdata[7:0];
      2'd1:    ld_byte = data_rdata[15:8];
      2'd2:    ld_byte = data_rdata[23:16];
      default: ld_byte = data_rdata[31:24];
    endcase
    ld_half = data_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (data_size)
      2'd0:    ld_aligned = {{24{ld_sign & ld_byte[7]}}, ld_byte};
      2'd1:    ld_aligned = {{16{ld_sign & ld_half[15]}}, ld_half};
      default: ld_aligned = data_rdata;
    endcase
  end

  always_comb begin
    state_nxt           = state;
    drain_addr_done_nxt = drain_addr_done;
    data_req            = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_REQ;
      S_REQ: begin
        data_req = 1'b1;
        if (flush) begin
          state_nxt           = S_DRAIN;
          drain_addr_done_nxt = data_addr_ok;
        end else if (data_addr_ok) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (data_data_ok) begin
          state_nxt = flush ? S_IDLE : S_DONE;
        end else if (flush) begin
          state_nxt           = S_DRAIN;
          drain_addr_done_nxt = 1'b1;
        end
      end
      S_DONE: if (advance | flush) state_nxt = S_IDLE;
      S_DRAIN: begin
        // The request is never withdrawn before the bus accepts the address.
        data_req = ~drain_addr_done;
        if (!drain_addr_done) begin
          if (data_addr_ok) drain_addr_done_nxt = 1'b1;
        end else if (data_data_ok) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= S_IDLE;
      drain_addr_done <= 1'b0;
      data_wr         <= 1'b0;
      data_size       <= 2'd0;
      data_addr       <= 32'd0;
      data_wdata      <= 32'd0;
      ld_sign         <= 1'b0;
      load_data       <= 32'd0;
    end else begin
      state           <= state_nxt;
      drain_addr_done <= drain_addr_done_nxt;
      if (start) begin
        data_wr    <= memwrite;
        data_size  <= size_map;
        data_addr  <= addr;
        data_wdata <= wdata_rep;
        ld_sign    <= sign_ext;
      end
      if (state == S_WAIT && data_data_ok && !flush && !data_wr)
        load_data <= ld_aligned;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalignment, drain, reset.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        resetn;
  logic        valid, memen, memwrite, sign_ext, advance, flush;
  logic [1:0]  size;
  logic [31:0] addr, wdata_in;
  logic        stall, adel, ades, data_req, data_wr;
  logic [31:0] load_data, data_addr, data_wdata, data_rdata;
  logic [1:0]  data_size;
  logic        data_addr_ok, data_data_ok;
  int          tests = 0;
  int          fails = 0;

  mem_access_unit dut (
    .clk(clk), .resetn(resetn), .valid(valid), .memen(memen),
    .memwrite(memwrite), .size(size), .sign_ext(sign_ext), .addr(addr),
    .wdata_in(wdata_in), .advance(advance), .flush(flush), .stall(stall),
    .load_data(load_data), .adel(adel), .ades(ades), .data_req(data_req),
    .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    valid = 0; memen = 0; memwrite = 0; size = 0; sign_ext = 0;
    addr = 0; wdata_in = 0; advance = 0; flush = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
  endtask

  // Load with addr_ok in cycle 1 and data_ok in cycle 2.
  task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic sx, input logic [31:0] rd, input logic [31:0] exp);
    valid = 1; memen = 1; memwrite = 0; size = sz; sign_ext = sx; addr = a;
    tick();
    data_addr_ok = 1;
    tick();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = rd;
    tick();
    data_data_ok = 0; data_rdata = 32'h0; advance = 1;
    #1;
    chk({tag, "_data"}, load_data, exp);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    resetn = 0;
    #12;
    chk("rst_req", {31'd0, data_req}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_addr", data_addr, 32'd0);
    chk("rst_wdata", data_wdata, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    resetn = 1;
    tick();

    // LW 0x1000: addr_ok in cycle 1, data_ok in cycle 4
    valid = 1; memen = 1; size = 2; addr = 32'h0000_1000;
    #1; chk("lw_c0_stall", {31'd0, stall}, 32'd1);
    tick();
    data_addr_ok = 1;
    #1;
    chk("lw_c1_req", {31'd0, data_req}, 32'd1);
    chk("lw_c1_addr", data_addr, 32'h0000_1000);
    chk("lw_c1_size", {30'd0, data_size}, 32'd2);
    chk("lw_c1_wr", {31'd0, data_wr}, 32'd0);
    chk("lw_c1_stall", {31'd0, stall}, 32'd1);
    tick();
    data_addr_ok = 0;
    #1; chk("lw_c2_req", {31'd0, data_req}, 32'd0);
    chk("lw_c2_stall", {31'd0, stall}, 32'd1);
    tick();
    #1; chk("lw_c3_stall", {31'd0, stall}, 32'd1);
    tick();
    data_data_ok = 1; data_rdata = 32'hDEAD_BEEF;
    #1; chk("lw_c4_stall", {31'd0, stall}, 32'd1);
    tick();
    data_data_ok = 0; data_rdata = 0; advance = 1;
    #1;
    chk("lw_c5_data", load_data, 32'hDEAD_BEEF);
    chk("lw_c5_stall", {31'd0, stall}, 32'd0);
    tick();
    idle_inputs();

    do_load("lb3_sx", 32'h0000_0103, 2'd0, 1'b1, 32'h8012_3456, 32'hFFFF_FF80);
    do_load("lb3_zx", 32'h0000_0103, 2'd0, 1'b0, 32'h8012_3456, 32'h0000_0080);
    do_load("lh2_sx", 32'h0000_0102, 2'd1, 1'b1, 32'h8012_3456, 32'hFFFF_8012);
    do_load("lh0_zx", 32'h0000_0100, 2'd1, 1'b0, 32'h8012_F456, 32'h0000_F456);
    do_load("lb1_zx", 32'h0000_0101, 2'd0, 1'b0, 32'h8012_3456, 32'h0000_0034);
    do_load("lw_rsv", 32'h0000_0200, 2'd3, 1'b0, 32'h1234_5678, 32'h1234_5678);

    // SH at 0x102
    valid = 1; memen = 1; memwrite = 1; size = 1; addr = 32'h0000_0102;
    wdata_in = 32'h0000_ABCD;
    tick();
    wdata_in = 32'hFFFF_FFFF;
    #1;
    chk("sh_wdata", data_wdata, 32'hABCD_ABCD);
    chk("sh_size", {30'd0, data_size}, 32'd1);
    chk("sh_wr", {31'd0, data_wr}, 32'd1);
    data_addr_ok = 1;
    tick();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h5555_5555;
    tick();
    data_data_ok = 0; advance = 1;
    #1;
    chk("sh_load_kept", load_data, 32'h1234_5678);
    chk("sh_stall", {31'd0, stall}, 32'd0);
    tick();
    idle_inputs();

    // SB replicates the low byte
    valid = 1; memen = 1; memwrite = 1; size = 0; addr = 32'h0000_0301;
    wdata_in = 32'h1234_5678;
    tick();
    #1; chk("sb_wdata", data_wdata, 32'h7878_7878);
    data_addr_ok = 1;
    tick();
    data_addr_ok = 0; data_data_ok = 1;
    tick();
    data_data_ok = 0; advance = 1;
    tick();
    idle_inputs();

    // Misaligned word load / store
    valid = 1; memen = 1; size = 2; addr = 32'h0000_0102;
    #1;
    chk("mis_adel", {31'd0, adel}, 32'd1);
    chk("mis_ades_ld", {31'd0, ades}, 32'd0);
    chk("mis_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("mis_req", {31'd0, data_req}, 32'd0);
    memwrite = 1;
    #1;
    chk("mis_ades", {31'd0, ades}, 32'd1);
    chk("mis_adel_st", {31'd0, adel}, 32'd0);
    tick();
    chk("mis_req_st", {31'd0, data_req}, 32'd0);
    idle_inputs();
    valid = 1; memen = 1; size = 1; addr = 32'h0000_0103;
    #1; chk("mis_half", {31'd0, adel}, 32'd1);
    idle_inputs();
    tick();

    // Flush in WAIT, then a new LW waits behind the drain
    valid = 1; memen = 1; size = 2; addr = 32'h0000_2000;
    tick();
    data_addr_ok = 1;
    tick();
    data_addr_ok = 0; flush = 1;
    #1; chk("fl_stall_flush", {31'd0, stall}, 32'd0);
    tick();
    flush = 0; addr = 32'h0000_3000;
    #1;
    chk("dr_stall", {31'd0, stall}, 32'd1);
    chk("dr_req", {31'd0, data_req}, 32'd0);
    tick();
    data_data_ok = 1; data_rdata = 32'hBADB_AD00;
    #1; chk("dr_stall2", {31'd0, stall}, 32'd1);
    tick();
    data_data_ok = 0; data_rdata = 0;
    #1;
    chk("dr_discard", load_data, 32'h1234_5678);
    chk("dr_new_stall", {31'd0, stall}, 32'd1);
    chk("dr_new_noreq", {31'd0, data_req}, 32'd0);
    tick();
    #1;
    chk("new_req", {31'd0, data_req}, 32'd1);
    chk("new_addr", data_addr, 32'h0000_3000);
    data_addr_ok = 1;
    tick();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h1111_2222;
    tick();
    data_data_ok = 0; advance = 1;
    #1;
    chk("new_data", load_data, 32'h1111_2222);
    chk("new_stall", {31'd0, stall}, 32'd0);
    tick();
    idle_inputs();

    // Asynchronous reset mid-request
    valid = 1; memen = 1; size = 2; addr = 32'h0000_4000;
    tick();
    #1; chk("ar_req_before", {31'd0, data_req}, 32'd1);
    resetn = 0;
    #1;
    chk("ar_req", {31'd0, data_req}, 32'd0);
    chk("ar_addr", data_addr, 32'd0);
    chk("ar_load", load_data, 32'd0);
    idle_inputs();
    #1;
    resetn = 1;
    tick();
    chk("ar_idle_req", {31'd0, data_req}, 32'd0);
    chk("ar_idle_stall", {31'd0, stall}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
